// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding,
// baud divisor rounding and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    function automatic int uart_div(input int clk_hz,
                                    input int baud,
                                    input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic logic maj3(input logic a,
                                  input logic b,
                                  input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divisor with synchronous clear.
// Shared by the UART receive and transmit paths.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit after the data.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    uart_state_e state_q, state_d;

    logic                 rx_m, rx_s, rx_p;
    logic                 fall, tick, clr;
    logic [TW-1:0]        tcnt;
    logic                 s0, s1;
    logic                 decide, maj;
    logic [3:0]           bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 commit, ferr_d;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= UART_RX;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    assign fall   = rx_p & ~rx_s;
    assign decide = tick && (tcnt == T_S2);
    assign maj    = maj3(s0, s1, rx_s);

    // BREAK holds the divisor cleared while low, so a tick there
    // means the line has been high for one full tick period.
    assign clr = ((state_q == ST_IDLE) && fall) ||
                 ((state_q == ST_BREAK) && !rx_s);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .sysclk(sysclk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state_q <= ST_BREAK;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE:  if (fall) state_d = ST_START;
            ST_START: if (decide) state_d = maj ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (decide && bcnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (decide) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (decide) begin
                    if (maj) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: if (tick && rx_s) state_d = ST_IDLE;
            default:  state_d = ST_BREAK;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tcnt  <= '0;
            s0    <= 1'b1;
            s1    <= 1'b1;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            if (state_q == ST_IDLE || state_q == ST_BREAK)
                tcnt <= '0;
            else if (tick)
                tcnt <= (tcnt == T_END) ? '0 : tcnt + TW'(1);
            if (tick && tcnt == T_S0) s0 <= rx_s;
            if (tick && tcnt == T_S1) s1 <= rx_s;
            if (decide && state_q == ST_START) bcnt <= '0;
            if (decide && state_q == ST_DATA) begin
                bcnt  <= bcnt + 4'd1;
                shreg <= {maj, shreg[DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (decide && state_q == ST_START)
                par_bad <= 1'b0;
            if (decide && state_q == ST_PARITY)
                par_bad <= maj ^ (^shreg) ^ (PARITY_ODD != 0);
            parity_err <= commit && par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= ferr_d;
            overrun_err <= commit && rx_valid && !rx_ready;
            if (commit && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
